// File: rtl/therm_dec_pkg.sv
//------------------------------------------------------------------------------
// therm_dec_pkg
// Shared FSM state type, default widths and a majority-vote helper for the
// thermometer decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package therm_dec_pkg;

  // Default thermometer word width and per-cycle segment width.
  localparam int W_DEFAULT = 512;
  localparam int S_DEFAULT = 64;

  // Decoder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 2-of-3 majority vote used to suppress single-bit bubbles.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_popcnt.sv
//------------------------------------------------------------------------------
// seg_popcnt
// Combinational population count of one S-bit segment.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_popcnt #(
  parameter int S = 64
) (
  input  logic [S-1:0]            seg,
  output logic [$clog2(S+1)-1:0]  count
);

  localparam int PW = $clog2(S+1);

  // Plain adder chain; synthesis rebalances it into a tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < S; i++) begin
      count = count + PW'(seg[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/therm_dec.sv
//------------------------------------------------------------------------------
// therm_dec
// Sequential thermometer-to-binary decoder. A strobe captures a W-bit
// thermometer word, which is then summed S bits per cycle. The result is
// presented on o_code with a one-cycle o_valid pulse; o_err flags a
// non-monotone captured word and o_ovf records strobes dropped while busy.
// Optional feature macro: THERM_DEC_BUBBLE_FIX_EN (majority-vote bubble
// correction applied to the captured word before counting).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module therm_dec
  import therm_dec_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int S = S_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [W-1:0]             i_therm,
  input  logic                     i_strobe,
  output logic [$clog2(W+1)-1:0]   o_code,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_err,
  output logic                     o_ovf
);

  localparam int CW   = $clog2(W+1);
  localparam int PW   = $clog2(S+1);
  localparam int NSEG = W / S;
  localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    captured;
  logic [W-1:0]    cap_word;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   acc_sum;
  logic [IW-1:0]   idx;
  logic            err_pend;
  logic            raw_err;
  logic [W-1:0]    therm_inc;
  logic [S-1:0]    seg;
  logic [PW-1:0]   seg_cnt;
  logic            last_seg;
  logic            capture;

`ifdef THERM_DEC_BUBBLE_FIX_EN
  // Pad with a virtual 1 below bit 0 and a virtual 0 above bit W-1.
  logic [W+1:0]    padded;
  assign padded = {1'b0, i_therm, 1'b1};

  for (genvar i = 0; i < W; i++) begin : g_bubble_fix
    assign cap_word[i] = maj3(padded[i], padded[i+1], padded[i+2]);
  end
`else
  assign cap_word = i_therm;
`endif

  // A word is monotone only if it has the form 2^k-1; adding one then
  // clears every set bit, so any surviving overlap exposes a 0 below a 1.
  assign therm_inc = i_therm + W'(1);
  assign raw_err   = |(i_therm & therm_inc);

  assign seg      = captured[idx*S +: S];
  assign acc_sum  = acc + CW'(seg_cnt);
  assign last_seg = (idx == IW'(NSEG - 1));
  assign capture  = i_strobe && (state != ACC);

  assign o_busy   = (state == ACC);
  assign o_valid  = (state == DONE);

  seg_popcnt #(
    .S     (S)
  ) u_seg_popcnt (
    .seg   (seg),
    .count (seg_cnt)
  );

  // State register; reset overrides any simultaneous strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: capture from IDLE/DONE, finish after the last segment.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_strobe) state_next = ACC;
      ACC:     if (last_seg) state_next = DONE;
      DONE:    state_next = i_strobe ? ACC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture, accumulate, publish the result and track dropped strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      captured <= '0;
      acc      <= '0;
      idx      <= '0;
      err_pend <= 1'b0;
      o_code   <= '0;
      o_err    <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      if (capture) begin
        captured <= cap_word;
        acc      <= '0;
        idx      <= '0;
        err_pend <= raw_err;
      end else if (state == ACC) begin
        acc <= acc_sum;
        idx <= idx + IW'(1);
        if (last_seg) begin
          o_code <= acc_sum;
          o_err  <= err_pend;
        end
      end
      if (i_strobe && (state == ACC)) begin
        o_ovf <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_therm_dec.sv
//------------------------------------------------------------------------------
// tb_therm_dec
// Self-checking testbench for therm_dec with a behavioural reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_therm_dec;

  localparam int W    = 512;
  localparam int S    = 64;
  localparam int NSEG = W / S;
  localparam int CW   = $clog2(W+1);
  localparam int LAT  = NSEG + 1;
  localparam int TMO  = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          strobe;
  logic [W-1:0]  therm;
  logic [CW-1:0] code;
  logic          valid, busy, err, ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  therm_dec #(.W(W), .S(S)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_therm  (therm),
    .i_strobe (strobe),
    .o_code   (code),
    .o_valid  (valid),
    .o_busy   (busy),
    .o_err    (err),
    .o_ovf    (ovf)
  );

  // Word with the k lowest bits set.
  function automatic logic [W-1:0] ones_word(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Reference: count ones (after optional majority repair) and detect a 0 below a 1.
  function automatic void model(input logic [W-1:0] w, output int cnt, output bit nonmono);
    int top;
    int ones;
    int votes;
    top  = -1;
    ones = 0;
    for (int i = 0; i < W; i++) if (w[i]) begin top = i; ones++; end
    nonmono = (ones != top + 1);
`ifdef THERM_DEC_BUBBLE_FIX_EN
    cnt = 0;
    for (int i = 0; i < W; i++) begin
      votes = int'(w[i]) + ((i == 0) ? 1 : int'(w[i-1])) + ((i == W-1) ? 0 : int'(w[i+1]));
      if (votes >= 2) cnt++;
    end
`else
    cnt = ones;
`endif
  endfunction

  // Strobe one word and wait (bounded) for o_valid; leaves the bench in the DONE cycle.
  task automatic decode(input logic [W-1:0] w, output int c, output bit e,
                        output int lat, output int busy_cycles, output bit tmo);
    @(negedge clk);
    therm  = w;
    strobe = 1'b1;
    @(negedge clk);
    strobe      = 1'b0;
    lat         = 1;
    busy_cycles = 0;
    while (!valid && lat < TMO) begin
      busy_cycles += int'(busy);
      @(negedge clk);
      lat++;
    end
    tmo = !valid;
    c   = int'(code);
    e   = err;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    strobe = 1'b1;
    therm  = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({code, valid, busy, err, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got code=%0d valid=%b busy=%b err=%b ovf=%b, want all 0",
               code, valid, busy, err, ovf);
    end
    rst    = 1'b0;
    strobe = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe_ignored: got busy=%b ovf=%b, want 0 0", busy, ovf);
    end
  endtask

  task automatic test_basic();
    int c, lat, bc;
    bit e, tmo;
    decode(ones_word(37), c, e, lat, bc, tmo);
    checks++;
    if (tmo || lat != LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles (timeout=%0d), want %0d", lat, tmo, LAT);
    end
    checks++;
    if (bc != NSEG) begin
      errors++;
      $display("FAIL basic_busy: got %0d busy cycles, want %0d", bc, NSEG);
    end
    checks++;
    if (c != 37 || e !== 1'b0) begin
      errors++;
      $display("FAIL basic_code: got code=%0d err=%b, want 37 0", c, e);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: got valid=%b one cycle later, want 0", valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (code !== CW'(37) || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got code=%0d err=%b, want 37 0", code, err);
    end
  endtask

  task automatic test_extremes();
    int c, lat, bc;
    bit e, tmo;
    decode('1, c, e, lat, bc, tmo);
    checks++;
    if (tmo || c != W || e !== 1'b0) begin
      errors++;
      $display("FAIL all_ones: got code=%0d err=%b timeout=%0d, want %0d 0", c, e, tmo, W);
    end
    decode('0, c, e, lat, bc, tmo);
    checks++;
    if (tmo || c != 0 || e !== 1'b0) begin
      errors++;
      $display("FAIL all_zeros: got code=%0d err=%b timeout=%0d, want 0 0", c, e, tmo);
    end
  endtask

  task automatic test_bubble();
    int c, lat, bc, want;
    bit e, tmo;
    logic [W-1:0] w;
    w     = ones_word(100);
    w[50] = 1'b0;
`ifdef THERM_DEC_BUBBLE_FIX_EN
    want = 100;
`else
    want = 99;
`endif
    decode(w, c, e, lat, bc, tmo);
    checks++;
    if (tmo || c != want || e !== 1'b1) begin
      errors++;
      $display("FAIL bubble: got code=%0d err=%b timeout=%0d, want %0d 1", c, e, tmo, want);
    end
  endtask

  // Strobes at cycles 0 and 3: the second one is dropped and latches o_ovf.
  task automatic test_ovf();
    int nvalid, vcyc, vcode;
    nvalid = 0; vcyc = -1; vcode = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (valid) begin
        nvalid++;
        if (vcyc < 0) begin vcyc = cyc; vcode = int'(code); end
      end
      strobe = (cyc == 0) || (cyc == 3);
      therm  = (cyc == 3) ? ones_word(10) : ones_word(200);
    end
    strobe = 1'b0;
    checks++;
    if (nvalid != 1 || vcyc != LAT || vcode != 200) begin
      errors++;
      $display("FAIL ovf_single_valid: got %0d pulses first at %0d code=%0d, want 1 at %0d code 200",
               nvalid, vcyc, vcode, LAT);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b, want 1", ovf);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b after reset, want 0", ovf);
    end
  endtask

  // Strobes at cycles 0 and 9: the second lands in DONE and is accepted.
  task automatic test_back_to_back();
    int vc[$];
    int cd[$];
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (valid) begin vc.push_back(cyc); cd.push_back(int'(code)); end
      strobe = (cyc == 0) || (cyc == LAT);
      therm  = (cyc == LAT) ? ones_word(451) : ones_word(64);
    end
    strobe = 1'b0;
    checks++;
    if (vc.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, want 2", vc.size());
    end else begin
      checks++;
      if (vc[0] != LAT || vc[1] != 2*LAT || cd[0] != 64 || cd[1] != 451) begin
        errors++;
        $display("FAIL b2b_codes: got cycles %0d,%0d codes %0d,%0d, want %0d,%0d codes 64,451",
                 vc[0], vc[1], cd[0], cd[1], LAT, 2*LAT);
      end
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_ovf: got ovf=%b, want 0", ovf);
    end
  endtask

  // Reset in the fourth ACC cycle aborts the decode silently.
  task automatic test_reset_abort();
    int nvalid, c, lat, bc;
    bit e, tmo, zero_ok;
    nvalid = 0; zero_ok = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (valid) nvalid++;
      if (cyc == 5) zero_ok = ({code, valid, busy, err, ovf} === '0);
      strobe = (cyc == 0) || (cyc == 4);
      rst    = (cyc == 4);
      therm  = ones_word(300);
    end
    strobe = 1'b0;
    rst    = 1'b0;
    checks++;
    if (nvalid != 0 || !zero_ok) begin
      errors++;
      $display("FAIL reset_abort: got %0d pulses, outputs_zero=%0d, want 0 pulses and zero outputs",
               nvalid, zero_ok);
    end
    decode(ones_word(123), c, e, lat, bc, tmo);
    checks++;
    if (tmo || c != 123 || e !== 1'b0 || lat != LAT) begin
      errors++;
      $display("FAIL after_abort: got code=%0d err=%b lat=%0d, want 123 0 %0d", c, e, lat, LAT);
    end
  endtask

  task automatic test_random();
    int c, lat, bc, k, mode, want;
    bit e, tmo, want_err;
    logic [W-1:0] w;
    for (int n = 0; n < 24; n++) begin
      k    = int'($urandom_range(0, W));
      mode = int'($urandom_range(0, 3));
      w    = ones_word(k);
      if ((mode == 1 || mode == 3) && k > 1)  w[$urandom_range(0, k-2)] = 1'b0;
      if ((mode == 2 || mode == 3) && k < W-1) w[$urandom_range(k+1, W-1)] = 1'b1;
      model(w, want, want_err);
      decode(w, c, e, lat, bc, tmo);
      checks++;
      if (tmo || c != want || e !== want_err || lat != LAT) begin
        errors++;
        $display("FAIL random[%0d] k=%0d mode=%0d: got code=%0d err=%b lat=%0d, want %0d %b %0d",
                 n, k, mode, c, e, lat, want, want_err, LAT);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    strobe = 1'b0;
    therm  = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_bubble();
    test_ovf();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
